// File: rtl/pcie_dllp_tx_scheduler.sv
// PCIe data link layer DLLP transmit scheduler: VC0 InitFC1/InitFC2 sequencing, then
// Ack/Nak and UpdateFC arbitration onto one AXI-stream port carrying the 32-bit DLLP body.
module pcie_dllp_tx_scheduler #(
    parameter logic [7:0]  P_HDR_CREDITS    = 8'h01,
    parameter logic [11:0] P_DATA_CREDITS   = 12'h040,
    parameter logic [7:0]  NP_HDR_CREDITS   = 8'h01,
    parameter logic [11:0] NP_DATA_CREDITS  = 12'h010,
    parameter logic [7:0]  CPL_HDR_CREDITS  = 8'h01,
    parameter logic [11:0] CPL_DATA_CREDITS = 12'h040,
    parameter int unsigned UPDATE_FC_PERIOD = 999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        link_up,
    input  logic        rx_fc1_done,
    input  logic        rx_fc2_done,
    input  logic        ack_req,
    input  logic        ack_nak,
    input  logic [11:0] ack_seq,
    input  logic [2:0]  upd_req,
    input  logic [23:0] upd_hdr_credits,
    input  logic [35:0] upd_data_credits,
    output logic [31:0] m_axis_dllp_tdata,
    output logic        m_axis_dllp_tvalid,
    input  logic        m_axis_dllp_tready,
    output logic [1:0]  dl_status,
    output logic        fc_init_done
);

    localparam int unsigned TMR_W = (UPDATE_FC_PERIOD > 1) ? $clog2(UPDATE_FC_PERIOD) : 1;

    typedef enum logic [1:0] {
        DL_DOWN   = 2'd0,
        DL_UP     = 2'd1,
        DL_ACTIVE = 2'd2
    } pcie_dl_status_e;

    typedef enum logic [3:0] {
        INIT_FCDLE, INIT_FC1_P, INIT_FC1_NP, INIT_FC1_CPL, CHECK_FC1_VALS,
        INIT_FC2_P, INIT_FC2_NP, INIT_FC2_CPL, CHECK_FC2_VALS, INIT_FC_COMPLETE
    } flow_control_state_e;

    function automatic logic [31:0] fc_word(input logic [7:0] ty, input logic [7:0] hdr,
                                            input logic [11:0] data);
        fc_word = {data[7:0], hdr[1:0], 2'b00, data[11:8], 2'b00, hdr[7:2], ty};
    endfunction

    function automatic logic [31:0] ack_word(input logic nak, input logic [11:0] seq);
        ack_word = {seq[7:0], 4'h0, seq[11:8], 8'h00, (nak ? 8'h10 : 8'h00)};
    endfunction

    flow_control_state_e state, state_nxt;
    pcie_dl_status_e     status_nxt_c;
    logic                ack_pend, ack_pend_nak;
    logic [11:0]         ack_pend_seq;
    logic [2:0]          upd_pend;
    logic [TMR_W-1:0]    refresh_tmr;

    logic                handshake_c, free_c, active_c, refresh_wrap_c;
    logic                load_c, ack_clr_c, is_send_c;
    logic [2:0]          upd_clr_c;
    logic [31:0]         word_c;
    logic [7:0]          init_ty_c, init_hdr_c;
    logic [11:0]         init_data_c;
    flow_control_state_e send_nxt_c;

    assign handshake_c    = m_axis_dllp_tvalid && m_axis_dllp_tready;
    assign free_c         = !m_axis_dllp_tvalid || m_axis_dllp_tready;
    assign active_c       = (state == INIT_FC_COMPLETE);
    assign refresh_wrap_c = active_c && (UPDATE_FC_PERIOD != 0) &&
                            (refresh_tmr == TMR_W'(UPDATE_FC_PERIOD - 1));

    // Next state, word selection and pending-flag clears
    always_comb begin
        state_nxt    = state;
        status_nxt_c = DL_UP;
        load_c       = 1'b0;
        word_c       = '0;
        ack_clr_c    = 1'b0;
        upd_clr_c    = 3'b000;
        is_send_c    = 1'b0;
        init_ty_c    = 8'h00;
        init_hdr_c   = 8'h00;
        init_data_c  = 12'h000;
        send_nxt_c   = state;

        case (state)
            INIT_FCDLE:     if (link_up) state_nxt = INIT_FC1_P;
            INIT_FC1_P:     begin is_send_c = 1'b1; init_ty_c = 8'h40; init_hdr_c = P_HDR_CREDITS;
                                  init_data_c = P_DATA_CREDITS;   send_nxt_c = INIT_FC1_NP;    end
            INIT_FC1_NP:    begin is_send_c = 1'b1; init_ty_c = 8'h50; init_hdr_c = NP_HDR_CREDITS;
                                  init_data_c = NP_DATA_CREDITS;  send_nxt_c = INIT_FC1_CPL;   end
            INIT_FC1_CPL:   begin is_send_c = 1'b1; init_ty_c = 8'h60; init_hdr_c = CPL_HDR_CREDITS;
                                  init_data_c = CPL_DATA_CREDITS; send_nxt_c = CHECK_FC1_VALS; end
            CHECK_FC1_VALS: state_nxt = rx_fc1_done ? INIT_FC2_P : INIT_FC1_P;
            INIT_FC2_P:     begin is_send_c = 1'b1; init_ty_c = 8'hC0; init_hdr_c = P_HDR_CREDITS;
                                  init_data_c = P_DATA_CREDITS;   send_nxt_c = INIT_FC2_NP;    end
            INIT_FC2_NP:    begin is_send_c = 1'b1; init_ty_c = 8'hD0; init_hdr_c = NP_HDR_CREDITS;
                                  init_data_c = NP_DATA_CREDITS;  send_nxt_c = INIT_FC2_CPL;   end
            INIT_FC2_CPL:   begin is_send_c = 1'b1; init_ty_c = 8'hE0; init_hdr_c = CPL_HDR_CREDITS;
                                  init_data_c = CPL_DATA_CREDITS; send_nxt_c = CHECK_FC2_VALS; end
            CHECK_FC2_VALS: state_nxt = rx_fc2_done ? INIT_FC_COMPLETE : INIT_FC2_P;
            INIT_FC_COMPLETE: begin
                if (free_c) begin
                    if (ack_pend) begin
                        load_c = 1'b1; ack_clr_c = 1'b1;
                        word_c = ack_word(ack_pend_nak, ack_pend_seq);
                    end else if (upd_pend[0]) begin
                        load_c = 1'b1; upd_clr_c = 3'b001;
                        word_c = fc_word(8'h80, upd_hdr_credits[7:0], upd_data_credits[11:0]);
                    end else if (upd_pend[1]) begin
                        load_c = 1'b1; upd_clr_c = 3'b010;
                        word_c = fc_word(8'h90, upd_hdr_credits[15:8], upd_data_credits[23:12]);
                    end else if (upd_pend[2]) begin
                        load_c = 1'b1; upd_clr_c = 3'b100;
                        word_c = fc_word(8'hA0, upd_hdr_credits[23:16], upd_data_credits[35:24]);
                    end
                end
            end
            default:        state_nxt = INIT_FCDLE;
        endcase

        // InitFC words go out only from an empty register so a triplet advances strictly on handshakes
        if (is_send_c) begin
            if (handshake_c) begin
                state_nxt = send_nxt_c;
            end else if (!m_axis_dllp_tvalid) begin
                load_c = 1'b1;
                word_c = fc_word(init_ty_c, init_hdr_c, init_data_c);
            end
        end

        if (!link_up) state_nxt = INIT_FCDLE;

        if (state_nxt == INIT_FCDLE)            status_nxt_c = DL_DOWN;
        else if (state_nxt == INIT_FC_COMPLETE) status_nxt_c = DL_ACTIVE;
    end

    // State, output register, pending flags and refresh timer
    always_ff @(posedge clk) begin
        if (rst || !link_up) begin
            state              <= INIT_FCDLE;
            m_axis_dllp_tdata  <= '0;
            m_axis_dllp_tvalid <= 1'b0;
            dl_status          <= DL_DOWN;
            fc_init_done       <= 1'b0;
            ack_pend           <= 1'b0;
            ack_pend_nak       <= 1'b0;
            ack_pend_seq       <= '0;
            upd_pend           <= '0;
            refresh_tmr        <= '0;
        end else begin
            state        <= state_nxt;
            dl_status    <= status_nxt_c;
            fc_init_done <= (state_nxt == INIT_FC_COMPLETE);

            if (load_c) begin
                m_axis_dllp_tdata  <= word_c;
                m_axis_dllp_tvalid <= 1'b1;
            end else if (handshake_c) begin
                m_axis_dllp_tvalid <= 1'b0;
            end

            // A Nak still waiting in the slot is never downgraded by a later Ack
            if (active_c && ack_req) begin
                ack_pend     <= 1'b1;
                ack_pend_nak <= ack_nak | (ack_pend & ~ack_clr_c & ack_pend_nak);
                ack_pend_seq <= ack_seq;
            end else if (ack_clr_c) begin
                ack_pend <= 1'b0;
            end

            upd_pend <= (upd_pend & ~upd_clr_c) | (active_c ? upd_req : 3'b000) |
                        (refresh_wrap_c ? 3'b111 : 3'b000);

            if (!active_c || refresh_wrap_c) refresh_tmr <= '0;
            else                             refresh_tmr <= refresh_tmr + TMR_W'(1);
        end
    end

endmodule
